// File: rtl/tx_uart.sv
// tx_uart: UART transmit serializer, start + data (LSB first) + even parity + stop; optional TX_HOLD_REG_EN adds a 1-entry holding register for back-to-back frames
module tx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic                        is_parity_stage
);
  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int IW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(INPUT_DATA_WIDTH - 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [INPUT_DATA_WIDTH-1:0] sh;
  logic [INPUT_DATA_WIDTH-1:0] ld_data;
  logic par;
  logic bit_end;
  logic accept;
  logic load;
  assign bit_end = (state != IDLE) && (cnt == CMAX);
  assign accept = tx_valid & tx_ready;
  assign tx_busy = state != IDLE;
  assign is_parity_stage = state == PARITY;
  assign serial_out = (state == START) ? 1'b0 :
                      (state == DATA) ? sh[0] :
                      (state == PARITY) ? par : 1'b1;
`ifdef TX_HOLD_REG_EN
  logic [INPUT_DATA_WIDTH-1:0] hold;
  logic hold_full;
  assign tx_ready = !hold_full;
  assign load = hold_full && ((state == IDLE) || (state == STOP && bit_end));
  assign ld_data = hold;
  // Holding register: a new byte wins over the move-out so a same-cycle accept keeps it full
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold <= tx_data;
      hold_full <= accept | (hold_full & ~load);
    end
  end
`else
  assign tx_ready = state == IDLE;
  assign load = accept;
  assign ld_data = tx_data;
`endif
  // Baud counter: free-runs in every non-IDLE state and wraps at the end of each bit
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
  end
  // Shift register and parity: load on frame start, shift right at the end of each data bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
      par <= 1'b0;
    end else if (load) begin
      sh <= ld_data;
      par <= ^ld_data;
    end else if (state == DATA && bit_end) begin
      sh <= sh >> 1;
    end
  end
  // Frame sequencer: all state and bit-index moves happen at bit_end; STOP chains straight to START when a byte is waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      case (state)
        IDLE: state <= load ? START : IDLE;
        START: state <= bit_end ? DATA : START;
        DATA: if (bit_end) begin
          idx <= (idx == IMAX) ? '0 : idx + 1'b1;
          state <= (idx == IMAX) ? PARITY : DATA;
        end
        PARITY: state <= bit_end ? STOP : PARITY;
        STOP: state <= bit_end ? (load ? START : IDLE) : STOP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
